gpio_config_sequencer: RTL

GPIO_CONFIG_SEQUENCER -- requirements
Module: gpio_config_sequencer

---
 rtl/gpio_seq_pkg.sv | 7 +
 rtl/gpio_config_sequencer_divider.sv | 17 +
 rtl/gpio_config_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: state encoding and sequence-length helper shared by gpio_config_sequencer.
package gpio_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_CLK_LO, S_CLK_HI, S_LOAD, S_FINISH} state_t;
   function automatic int unsigned seq_cycles(input int unsigned n, input int unsigned w, input int unsigned d);
      return n * (2 + 2 * d * w) + d + 1;
   endfunction
endpackage

// File: rtl/gpio_config_sequencer_divider.sv
// gpio_seq_divider: CLK_DIV half-period timer; i_load restarts it, o_tick marks the last cycle of a period.
module gpio_seq_divider #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_load,
   output logic o_tick
);
   logic [7:0] r_cnt;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_cnt <= '0;
      else if (i_load) r_cnt <= 8'(CLK_DIV - 1);
      else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
   end
   assign o_tick = (r_cnt == 8'd0);
endmodule

// File: rtl/gpio_config_sequencer.sv
// gpio_config_sequencer: reads per-pad config words and shifts them MSB-first into a GPIO config chain.
// Optional GPIO_SEQ_AUTOLOAD_EN: one automatic chain load on the second clk edge after reset release.
module gpio_config_sequencer
   import gpio_seq_pkg::*;
#(
   parameter int NUM_GPIO  = 38,
   parameter int CFG_WIDTH = 10,
   parameter int CLK_DIV   = 2
) (
   input  logic                                               clk,
   input  logic                                               resetn,
   input  logic                                               start,
   input  logic                                               abort,
   output logic                                               busy,
   output logic                                               done,
   output logic                                               cfg_rd,
   output logic [((NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1)-1:0] cfg_idx,
   input  logic [CFG_WIDTH-1:0]                               cfg_data,
   output logic                                               serial_clock,
   output logic                                               serial_data,
   output logic                                               serial_load
);
   localparam int IW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
   localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
   state_t               r_state, w_next;
   logic [IW-1:0]        r_idx, w_idx;
   logic [BW-1:0]        r_bit, w_bit;
   logic [CFG_WIDTH-1:0] r_shift, w_shift;
   logic                 w_tick, w_start, w_load;
`ifdef GPIO_SEQ_AUTOLOAD_EN
   logic [1:0] r_auto;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_auto <= '0;
      else if (r_auto != 2'd2) r_auto <= r_auto + 2'd1;
   end
   assign w_start = (start | (r_auto == 2'd1)) & ~abort;
`else
   assign w_start = start & ~abort;
`endif
   // Every state change restarts the half-period timer, so timed states always get a full CLK_DIV.
   assign w_load = (w_next != r_state);
   gpio_seq_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (clk),
      .resetn (resetn),
      .i_load (w_load),
      .o_tick (w_tick)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start) w_next = S_FETCH;
         S_FETCH:   w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_CLK_LO;
         S_CLK_LO:  if (w_tick) w_next = S_CLK_HI;
         S_CLK_HI:  if (w_tick) w_next = (r_bit != '0) ? S_CLK_LO : (r_idx != '0) ? S_FETCH : S_LOAD;
         S_LOAD:    if (w_tick) w_next = S_FINISH;
         S_FINISH:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (abort && r_state != S_IDLE) w_next = S_IDLE;
   end
   always_comb begin
      w_idx   = (r_state == S_IDLE) ? IW'(NUM_GPIO - 1) : r_idx;
      w_bit   = (r_state == S_CAPTURE) ? BW'(CFG_WIDTH - 1) : r_bit;
      w_shift = (r_state == S_CAPTURE) ? cfg_data : r_shift;
      if (r_state == S_CLK_HI && w_tick) begin
         w_shift = r_shift << 1;
         if (r_bit != '0) w_bit = r_bit - BW'(1);
         else if (r_idx != '0) w_idx = r_idx - IW'(1);
      end
   end
   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_rd       <= 1'b0;
         cfg_idx      <= '0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_idx        <= w_idx;
         r_bit        <= w_bit;
         r_shift      <= w_shift;
         busy         <= (w_next != S_IDLE);
         done         <= (w_next == S_FINISH);
         cfg_rd       <= (w_next == S_FETCH);
         serial_clock <= (w_next == S_CLK_HI);
         serial_load  <= (w_next == S_LOAD);
         if (w_next == S_FETCH) cfg_idx <= w_idx;
         if (w_next == S_CLK_LO) serial_data <= w_shift[CFG_WIDTH-1];
      end
   end
endmodule
